// File: rtl/ll_mux_scheduler_if.sv
// Sample-in / result-out handshake bundle for the line-length scheduler.
interface ll_mux_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_W       = 2,
  parameter int ACC_W      = 41
);
  logic signed [DATA_WIDTH-1:0] din;
  logic [CH_W-1:0]              din_ch;
  logic                         din_valid;
  logic                         din_ready;
  logic [ACC_W-1:0]             dout;
  logic [CH_W-1:0]              dout_ch;
  logic                         dout_flag;
  logic                         dout_valid;
  logic                         dout_ready;

  // Producer of samples / consumer of results
  modport master (
    output din, din_ch, din_valid, dout_ready,
    input  din_ready, dout, dout_ch, dout_flag, dout_valid
  );

  // The scheduler itself
  modport slave (
    input  din, din_ch, din_valid, dout_ready,
    output din_ready, dout, dout_ch, dout_flag, dout_valid
  );
endinterface

// File: rtl/ll_mux_scheduler.sv
// Line-length (sum of |x[n]-x[n-1]|) datapath shared by NUM_CH channels.
// One tagged sample per cycle; per-channel prev/acc/count; single-entry
// result buffer with valid/ready on both sides.
module ll_mux_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int WIN_LEN    = 256,
  parameter int CNT_W      = 9,
  parameter int ACC_W      = 41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] threshold,
  output logic             err_ch,
  output logic [15:0]      win_count,
  ll_mux_scheduler_if.slave bus
);

  typedef enum logic {UNPRIMED = 1'b0, ACCUM = 1'b1} ch_state_t;

  // State arrays span the whole id space so any din_ch indexes in range;
  // ids >= NUM_CH are never written.
  localparam int               NUM_SLOT = 1 << CH_W;
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  // |a - b| at one extra bit so the difference can never overflow
  function automatic logic [DATA_WIDTH:0] abs_diff(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] d;
    d = $signed({a[DATA_WIDTH-1], a}) - $signed({b[DATA_WIDTH-1], b});
    return d[DATA_WIDTH] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Accumulate with clamp at the accumulator's full-scale value
  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0]    acc,
    input logic [DATA_WIDTH:0] a
  );
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(a);
    return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
  endfunction

  ch_state_t                    r_state [NUM_SLOT];
  logic signed [DATA_WIDTH-1:0] r_prev  [NUM_SLOT];
  logic [ACC_W-1:0]             r_acc   [NUM_SLOT];
  logic [CNT_W-1:0]             r_cnt   [NUM_SLOT];

  logic [ACC_W-1:0] r_dout;
  logic [CH_W-1:0]  r_dout_ch;
  logic             r_dout_flag;
  logic             r_dout_valid;
  logic             r_err_ch;
  logic [15:0]      r_win_count;

  logic                w_ch_ok;
  logic                w_accept;
  logic                w_upd;
  logic                w_take;
  logic                w_primed;
  logic                w_close;
  logic [DATA_WIDTH:0] w_abs;
  logic [ACC_W-1:0]    w_sum;

  assign w_ch_ok  = {1'b0, bus.din_ch} < NUM_CH_L;
  assign bus.din_ready = en & ~rst & (~r_dout_valid | bus.dout_ready);
  assign w_accept = bus.din_valid & bus.din_ready;
  assign w_upd    = w_accept & w_ch_ok;
  assign w_take   = r_dout_valid & bus.dout_ready;
  assign w_primed = (r_state[bus.din_ch] == ACCUM);
  assign w_close  = w_primed & (r_cnt[bus.din_ch] == LAST_CNT);
  assign w_abs    = abs_diff(bus.din, r_prev[bus.din_ch]);
  assign w_sum    = sat_add(r_acc[bus.din_ch], w_abs);

  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_flag  = r_dout_flag;
  assign bus.dout_valid = r_dout_valid;
  assign err_ch         = r_err_ch;
  assign win_count      = r_win_count;

  // Per-channel FSM: first sample primes prev, later samples accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOT; i++) begin
        r_state[i] <= UNPRIMED;
        r_prev[i]  <= '0;
        r_acc[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else if (w_upd) begin
      r_prev[bus.din_ch]  <= bus.din;
      r_state[bus.din_ch] <= ACCUM;
      if (w_primed) begin
        if (w_close) begin
          r_acc[bus.din_ch] <= '0;
          r_cnt[bus.din_ch] <= '0;
        end else begin
          r_acc[bus.din_ch] <= w_sum;
          r_cnt[bus.din_ch] <= r_cnt[bus.din_ch] + 1'b1;
        end
      end
    end
  end

  // Result buffer: load on window close, otherwise drain on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_flag  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_err_ch     <= 1'b0;
      r_win_count  <= '0;
    end else begin
      r_err_ch <= w_accept & ~w_ch_ok;
      if (w_upd && w_close) begin
        r_dout       <= w_sum;
        r_dout_ch    <= bus.din_ch;
        r_dout_flag  <= (w_sum > threshold);
        r_dout_valid <= 1'b1;
        r_win_count  <= r_win_count + 16'd1;
      end else if (w_take) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ll_mux_scheduler.sv
// Bench for ll_mux_scheduler: directed scenarios plus random traffic,
// all checked against a sample-level reference model.
module tb_ll_mux_scheduler;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_CH     = 2;
  localparam int CH_W       = 2;
  localparam int WIN_LEN    = 4;
  localparam int CNT_W      = 3;
  localparam int ACC_W      = 35;
  localparam longint ACC_MAXL = (64'd1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [ACC_W-1:0] threshold;
  logic err_ch;
  logic [15:0] win_count;

  ll_mux_scheduler_if #(.DATA_WIDTH(DATA_WIDTH), .CH_W(CH_W), .ACC_W(ACC_W)) bus ();

  ll_mux_scheduler #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W),
    .WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .threshold(threshold),
    .err_ch(err_ch), .win_count(win_count), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: per channel history, single result slot
  bit     m_primed [NUM_CH];
  longint m_prev   [NUM_CH];
  longint m_acc    [NUM_CH];
  int     m_cnt    [NUM_CH];
  bit     m_valid;
  longint m_dout;
  int     m_ch;
  bit     m_flag;
  bit     m_err;
  int     m_wins;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_primed[i] = 1'b0; m_prev[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
    end
    m_valid = 0; m_dout = 0; m_ch = 0; m_flag = 0; m_err = 0; m_wins = 0;
  endtask

  // One clock: drive at negedge, predict across posedge, check at next negedge
  task automatic tick(input bit v, input int ch, input int val, input bit dr, input bit e);
    bit exp_rdy, acc, take;
    longint sval, a, s;
    bus.din_valid = v; bus.din_ch = ch[CH_W-1:0]; bus.din = val;
    bus.dout_ready = dr; en = e;
    #1;
    exp_rdy = e & (!m_valid | dr);
    chk("din_ready", longint'(bus.din_ready), longint'(exp_rdy));
    acc  = v & exp_rdy;
    take = m_valid & dr;
    @(posedge clk);
    sval  = longint'(val);
    m_err = acc && (ch >= NUM_CH);
    if (take) m_valid = 0;
    if (acc && ch < NUM_CH) begin
      if (!m_primed[ch]) begin
        m_primed[ch] = 1'b1;
      end else begin
        a = sval - m_prev[ch];
        if (a < 0) a = -a;
        s = m_acc[ch] + a;
        if (s > ACC_MAXL) s = ACC_MAXL;
        if (m_cnt[ch] == WIN_LEN - 1) begin
          m_valid = 1; m_dout = s; m_ch = ch; m_flag = (s > longint'(threshold));
          m_wins = (m_wins + 1) % 65536;
          m_acc[ch] = 0; m_cnt[ch] = 0;
        end else begin
          m_acc[ch] = s; m_cnt[ch]++;
        end
      end
      m_prev[ch] = sval;
    end
    @(negedge clk);
    chk("dout_valid", longint'(bus.dout_valid), longint'(m_valid));
    chk("err_ch", longint'(err_ch), longint'(m_err));
    chk("win_count", longint'(win_count), longint'(m_wins));
    if (m_valid) begin
      chk("dout", longint'(bus.dout), m_dout);
      chk("dout_ch", longint'(bus.dout_ch), longint'(m_ch));
      chk("dout_flag", longint'(bus.dout_flag), longint'(m_flag));
    end
  endtask

  // Reset with a live sample on the input to show rst overrides it
  task automatic do_reset();
    rst = 1; en = 1; bus.din_valid = 1; bus.din_ch = '0; bus.din = 7;
    bus.dout_ready = 0;
    #1;
    chk("rst_din_ready", longint'(bus.din_ready), 0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 0; bus.din_valid = 0;
    chk("rst_dout_valid", longint'(bus.dout_valid), 0);
    chk("rst_dout", longint'(bus.dout), 0);
    chk("rst_dout_ch", longint'(bus.dout_ch), 0);
    chk("rst_dout_flag", longint'(bus.dout_flag), 0);
    chk("rst_err_ch", longint'(err_ch), 0);
    chk("rst_win_count", longint'(win_count), 0);
  endtask

  int s1 [5] = '{0, 1, 10, 4, 6};
  int ext [5];

  initial begin
    rst = 0; en = 0; threshold = 35'd15;
    bus.din_valid = 0; bus.din_ch = '0; bus.din = 0; bus.dout_ready = 0;
    model_clear();
    @(negedge clk);

    // 1: single channel window
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, s1[i], 1, 1);
    chk("s1_dout", longint'(bus.dout), 18);
    chk("s1_flag", longint'(bus.dout_flag), 1);
    chk("s1_wins", longint'(win_count), 1);
    tick(0, 0, 0, 1, 1);
    chk("s1_valid_drop", longint'(bus.dout_valid), 0);

    // 2: interleaved channels
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, s1[i], 1, 1);
      if (i == 4) chk("s2_ch0", longint'(bus.dout), 18);
      tick(1, 1, 5, 1, 1);
    end
    chk("s2_ch1_dout", longint'(bus.dout), 0);
    chk("s2_ch1_id", longint'(bus.dout_ch), 1);
    chk("s2_wins", longint'(win_count), 2);

    // 3: back-pressure, then same-edge drain and reload
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 1, 5, 0, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, s1[i], 0, 1);
    tick(1, 1, 5, 0, 1);
    chk("s3_hold_dout", longint'(bus.dout), 18);
    chk("s3_hold_ch", longint'(bus.dout_ch), 0);
    tick(1, 1, 5, 1, 1);
    chk("s3_new_dout", longint'(bus.dout), 0);
    chk("s3_new_ch", longint'(bus.dout_ch), 1);
    chk("s3_new_valid", longint'(bus.dout_valid), 1);

    // 4: full-scale swings
    do_reset();
    ext = '{int'(32'h8000_0000), int'(32'h7FFF_FFFF), int'(32'h8000_0000),
            int'(32'h7FFF_FFFF), int'(32'h8000_0000)};
    for (int i = 0; i < 5; i++) tick(1, 0, ext[i], 1, 1);
    chk("s4_dout", longint'(bus.dout), 64'd17179869180);
    chk("s4_flag", longint'(bus.dout_flag), 1);

    // 5: bad channel id mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 0, s1[i], 1, 1);
    tick(1, 3, 999, 1, 1);
    chk("s5_err_pulse", longint'(err_ch), 1);
    tick(1, 0, s1[3], 1, 1);
    chk("s5_err_clear", longint'(err_ch), 0);
    tick(1, 0, s1[4], 1, 1);
    chk("s5_dout", longint'(bus.dout), 18);

    // 6: reset mid-window with a result pending
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 0, s1[i], 0, 1);
    for (int i = 0; i < 5; i++) tick(1, 1, 5, 0, 1);
    chk("s6_pending", longint'(bus.dout_valid), 1);
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, s1[i], 1, 1);
    chk("s6_dout", longint'(bus.dout), 18);

    // 7: random traffic, including bad ids, stalls and enable gaps
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int ch, val;
      if (n % 64 == 0) threshold = (n % 128 == 0) ? 35'($urandom_range(0, 60))
                                                  : {3'($urandom), 32'($urandom)};
      ch  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NUM_CH - 1);
      val = ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 40) - 20;
      tick($urandom_range(0, 3) != 0, ch, val, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
